// File: rtl/bug_game_pkg.sv
// Shared types and default constants for the bug-chase game sequencer.
package bug_game_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned GS_W    = 2;

  localparam int unsigned BUG_W_DEF        = 53;
  localparam int unsigned BUG_H_DEF        = 54;
  localparam int unsigned LIVES_DEF        = 3;
  localparam int unsigned INIT_DIV_DEF     = 40000;
  localparam int unsigned DIV_DEC_DEF      = 4000;
  localparam int unsigned MIN_DIV_DEF      = 8000;
  localparam int unsigned HIT_FRAMES_DEF   = 30;
  localparam int unsigned ROUND_FRAMES_DEF = 600;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_PLAY = 3'd2,
    ST_HIT  = 3'd3,
    ST_OVER = 3'd4
  } state_e;

  typedef enum logic [GS_W-1:0] {
    GS_IDLE = 2'd0,
    GS_PLAY = 2'd1,
    GS_HIT  = 2'd2,
    GS_OVER = 2'd3
  } game_state_e;

  // ARM is a transient part of play and is reported as PLAY.
  function automatic game_state_e state_code(input state_e s);
    case (s)
      ST_ARM, ST_PLAY: return GS_PLAY;
      ST_HIT:          return GS_HIT;
      ST_OVER:         return GS_OVER;
      default:         return GS_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/bug_game_ctl_if.sv
// Mouse/bug inputs and mover/overlay outputs of the game sequencer.
interface bug_game_ctl_if;
  import bug_game_pkg::*;

  logic               mouse_left;
  logic [COORD_W-1:0] mouse_xpos;
  logic [COORD_W-1:0] mouse_ypos;
  logic [COORD_W-1:0] bug_xpos;
  logic [COORD_W-1:0] bug_ypos;
  logic               frame_tick;
  logic               bug_rst;
  logic               bug_start;
  logic [DIV_W-1:0]   step_div;
  logic [SCORE_W-1:0] score;
  logic [LIVES_W-1:0] lives;
  logic [GS_W-1:0]    game_state;
  logic               hit_flash;

  modport master (
    output mouse_left, mouse_xpos, mouse_ypos, bug_xpos, bug_ypos, frame_tick,
    input  bug_rst, bug_start, step_div, score, lives, game_state, hit_flash
  );

  modport slave (
    input  mouse_left, mouse_xpos, mouse_ypos, bug_xpos, bug_ypos, frame_tick,
    output bug_rst, bug_start, step_div, score, lives, game_state, hit_flash
  );
endinterface

// File: rtl/bug_game_ctl_mouse_click_edge.sv
// Rising-edge detector on a pclk-synchronous button level.
module mouse_click_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic click_c
);
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= level;
  end

  assign click_c = level & ~prev_q;
endmodule

// File: rtl/bug_game_ctl.sv
// Bug-chase game sequencer: hit test, score/lives, mover control.
// Optional round timeout is built when BUG_GAME_TIMEOUT_EN is defined.
module bug_game_ctl
  import bug_game_pkg::*;
#(
  parameter int unsigned BUG_W        = BUG_W_DEF,
  parameter int unsigned BUG_H        = BUG_H_DEF,
  parameter int unsigned LIVES        = LIVES_DEF,
  parameter int unsigned INIT_DIV     = INIT_DIV_DEF,
  parameter int unsigned DIV_DEC      = DIV_DEC_DEF,
  parameter int unsigned MIN_DIV      = MIN_DIV_DEF,
  parameter int unsigned HIT_FRAMES   = HIT_FRAMES_DEF,
  parameter int unsigned ROUND_FRAMES = ROUND_FRAMES_DEF
) (
  input  logic          pclk,
  input  logic          rst,
  bug_game_ctl_if.slave io
);
  localparam int unsigned HIT_CNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
  localparam int unsigned CMP_W     = COORD_W + 1;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [DIV_W-1:0]   step_div_q, step_div_d;
  logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic               bug_rst_q, bug_rst_d;
  logic               bug_start_q, bug_start_d;
  logic               hit_flash_q, hit_flash_d;
  game_state_e        game_state_q, game_state_d;

  logic               click_c;
  logic               hit_c;
  logic               timeout_c;
  logic [LIVES_W-1:0] lives_dec_c;
  logic [DIV_W-1:0]   div_next_c;
  logic [CMP_W-1:0]   mx_c, my_c, bx_c, by_c;

  mouse_click_edge u_click (
    .clk     (pclk),
    .rst     (rst),
    .level   (io.mouse_left),
    .click_c (click_c)
  );

  // Widened compare so bug_pos + size cannot wrap at the screen edge.
  always_comb begin
    mx_c  = {1'b0, io.mouse_xpos};
    my_c  = {1'b0, io.mouse_ypos};
    bx_c  = {1'b0, io.bug_xpos};
    by_c  = {1'b0, io.bug_ypos};
    hit_c = (bx_c <= mx_c) && (mx_c < bx_c + CMP_W'(BUG_W)) &&
            (by_c <= my_c) && (my_c < by_c + CMP_W'(BUG_H));
  end

  always_comb begin
    lives_dec_c = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
    if ({1'b0, step_div_q} < (17'(MIN_DIV) + 17'(DIV_DEC))) div_next_c = DIV_W'(MIN_DIV);
    else                                                    div_next_c = step_div_q - DIV_W'(DIV_DEC);
  end

`ifdef BUG_GAME_TIMEOUT_EN
  localparam int unsigned RND_CNT_W = (ROUND_FRAMES > 1) ? $clog2(ROUND_FRAMES) : 1;
  logic [RND_CNT_W-1:0] round_cnt_q, round_cnt_d;
  logic                 round_last_c;

  always_comb begin
    round_last_c = (round_cnt_q == RND_CNT_W'(ROUND_FRAMES - 1));
    timeout_c    = (state_q == ST_PLAY) && io.frame_tick && round_last_c;
    round_cnt_d  = round_cnt_q;
    if (state_q == ST_ARM)
      round_cnt_d = '0;
    else if ((state_q == ST_PLAY) && io.frame_tick)
      round_cnt_d = round_last_c ? '0 : round_cnt_q + RND_CNT_W'(1);
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    lives_d    = lives_q;
    step_div_d = step_div_q;
    hit_cnt_d  = hit_cnt_q;

    case (state_q)
      ST_IDLE: if (click_c) begin
        state_d    = ST_ARM;
        score_d    = '0;
        lives_d    = LIVES_W'(LIVES);
        step_div_d = DIV_W'(INIT_DIV);
      end
      ST_ARM: state_d = ST_PLAY;
      ST_PLAY: begin
        // A click takes priority over a coincident timeout.
        if (click_c) begin
          if (hit_c) begin
            score_d    = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
            step_div_d = div_next_c;
            hit_cnt_d  = '0;
            state_d    = ST_HIT;
          end else begin
            lives_d = lives_dec_c;
            if (lives_dec_c == '0) state_d = ST_OVER;
          end
        end else if (timeout_c) begin
          lives_d = lives_dec_c;
          state_d = (lives_dec_c == '0) ? ST_OVER : ST_ARM;
        end
      end
      ST_HIT: if (io.frame_tick) begin
        if (hit_cnt_q == HIT_CNT_W'(HIT_FRAMES - 1)) begin
          hit_cnt_d = '0;
          state_d   = ST_ARM;
        end else begin
          hit_cnt_d = hit_cnt_q + HIT_CNT_W'(1);
        end
      end
      ST_OVER: if (click_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    bug_rst_d    = !((state_d == ST_ARM) || (state_d == ST_PLAY));
    bug_start_d  = (state_d == ST_ARM);
    hit_flash_d  = (state_d == ST_HIT);
    game_state_d = state_code(state_d);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      score_q      <= '0;
      lives_q      <= '0;
      step_div_q   <= DIV_W'(INIT_DIV);
      hit_cnt_q    <= '0;
      bug_rst_q    <= 1'b1;
      bug_start_q  <= 1'b0;
      hit_flash_q  <= 1'b0;
      game_state_q <= GS_IDLE;
`ifdef BUG_GAME_TIMEOUT_EN
      round_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      step_div_q   <= step_div_d;
      hit_cnt_q    <= hit_cnt_d;
      bug_rst_q    <= bug_rst_d;
      bug_start_q  <= bug_start_d;
      hit_flash_q  <= hit_flash_d;
      game_state_q <= game_state_d;
`ifdef BUG_GAME_TIMEOUT_EN
      round_cnt_q  <= round_cnt_d;
`endif
    end
  end

  assign io.bug_rst    = bug_rst_q;
  assign io.bug_start  = bug_start_q;
  assign io.step_div   = step_div_q;
  assign io.score      = score_q;
  assign io.lives      = lives_q;
  assign io.game_state = game_state_q;
  assign io.hit_flash  = hit_flash_q;
endmodule

// File: tb/tb_bug_game_ctl.sv
// Directed bench for bug_game_ctl; timeout checks follow BUG_GAME_TIMEOUT_EN.
module tb_bug_game_ctl;
  logic pclk = 1'b0;
  logic rst  = 1'b0;
  int   n_checks = 0;
  int   n_errs   = 0;

  bug_game_ctl_if io ();

  bug_game_ctl dut (
    .pclk (pclk),
    .rst  (rst),
    .io   (io)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      io.frame_tick = 1'b1;
      cyc(1);
      io.frame_tick = 1'b0;
    end
  endtask

  // One low cycle, then a one-cycle press; returns just after the click edge.
  task automatic do_click(input int x, input int y);
    io.mouse_left = 1'b0;
    cyc(1);
    io.mouse_xpos = 12'(x);
    io.mouse_ypos = 12'(y);
    io.mouse_left = 1'b1;
    cyc(1);
    io.mouse_left = 1'b0;
  endtask

  function automatic int exp_div(input int k);
    int v;
    v = 40000 - 4000 * k;
    return (v < 8000) ? 8000 : v;
  endfunction

  initial begin
    io.mouse_left = 1'b0;
    io.mouse_xpos = '0;
    io.mouse_ypos = '0;
    io.bug_xpos   = 12'd100;
    io.bug_ypos   = 12'd100;
    io.frame_tick = 1'b0;

    #3 rst = 1'b1;
    #14;
    chk("rst_gs",       32'(io.game_state), 0);
    chk("rst_bug_rst",  32'(io.bug_rst), 1);
    chk("rst_start",    32'(io.bug_start), 0);
    chk("rst_div",      32'(io.step_div), 40000);
    chk("rst_score",    32'(io.score), 0);
    chk("rst_lives",    32'(io.lives), 0);
    chk("rst_flash",    32'(io.hit_flash), 0);
    @(negedge pclk) rst = 1'b0;
    cyc(1);

    // Start with the button held across IDLE->ARM->PLAY.
    io.mouse_left = 1'b1;
    cyc(1);
    chk("arm_gs",      32'(io.game_state), 1);
    chk("arm_start",   32'(io.bug_start), 1);
    chk("arm_bug_rst", 32'(io.bug_rst), 0);
    chk("arm_lives",   32'(io.lives), 3);
    chk("arm_score",   32'(io.score), 0);
    chk("arm_div",     32'(io.step_div), 40000);
    cyc(1);
    chk("play_start",  32'(io.bug_start), 0);
    chk("play_gs",     32'(io.game_state), 1);
    cyc(2);
    chk("held_lives",  32'(io.lives), 3);
    io.mouse_left = 1'b0;

    io.bug_xpos = 12'd200;
    io.bug_ypos = 12'd200;
    do_click(252, 253);
    chk("hit1_gs",    32'(io.game_state), 2);
    chk("hit1_score", 32'(io.score), 1);
    chk("hit1_div",   32'(io.step_div), 36000);
    chk("hit1_flash", 32'(io.hit_flash), 1);
    chk("hit1_brst",  32'(io.bug_rst), 1);
    tick_frames(29);
    chk("hit29_gs",   32'(io.game_state), 2);
    tick_frames(1);
    chk("rearm_gs",    32'(io.game_state), 1);
    chk("rearm_start", 32'(io.bug_start), 1);
    chk("rearm_flash", 32'(io.hit_flash), 0);
    cyc(1);
    chk("rearm_start_end", 32'(io.bug_start), 0);

    do_click(253, 200);
    chk("miss_lives", 32'(io.lives), 2);
    chk("miss_gs",    32'(io.game_state), 1);

    for (int k = 2; k <= 9; k++) begin
      do_click(200, 200);
      chk("hitk_div",   32'(io.step_div), 32'(exp_div(k)));
      chk("hitk_score", 32'(io.score), 32'(k));
      tick_frames(30);
      cyc(1);
    end

    do_click(210, 210);
    do_click(0, 0);
    chk("hit_ignore_lives", 32'(io.lives), 2);
    chk("hit_ignore_gs",    32'(io.game_state), 2);
    tick_frames(30);
    cyc(1);

    do_click(199, 200);
    chk("miss2_lives", 32'(io.lives), 1);
    do_click(200, 254);
    chk("over_lives", 32'(io.lives), 0);
    chk("over_gs",    32'(io.game_state), 3);
    chk("over_brst",  32'(io.bug_rst), 1);
    chk("over_score", 32'(io.score), 10);
    do_click(210, 210);
    chk("idle_gs",    32'(io.game_state), 0);
    chk("idle_start", 32'(io.bug_start), 0);
    chk("idle_score", 32'(io.score), 10);
    do_click(0, 0);
    chk("new_gs",    32'(io.game_state), 1);
    chk("new_score", 32'(io.score), 0);
    chk("new_lives", 32'(io.lives), 3);
    chk("new_div",   32'(io.step_div), 40000);
    cyc(1);

`ifdef BUG_GAME_TIMEOUT_EN
    tick_frames(599);
    chk("to599_lives", 32'(io.lives), 3);
    tick_frames(1);
    chk("to_lives", 32'(io.lives), 2);
    chk("to_gs",    32'(io.game_state), 1);
    chk("to_start", 32'(io.bug_start), 1);
    cyc(1);
    tick_frames(599);
    io.mouse_xpos = 12'd210;
    io.mouse_ypos = 12'd210;
    io.frame_tick = 1'b1;
    io.mouse_left = 1'b1;
    cyc(1);
    io.frame_tick = 1'b0;
    io.mouse_left = 1'b0;
    chk("to_hit_gs",    32'(io.game_state), 2);
    chk("to_hit_score", 32'(io.score), 1);
    chk("to_hit_lives", 32'(io.lives), 2);
    tick_frames(30);
    cyc(1);
    tick_frames(599);
    io.mouse_xpos = 12'd0;
    io.mouse_ypos = 12'd0;
    io.frame_tick = 1'b1;
    io.mouse_left = 1'b1;
    cyc(1);
    io.frame_tick = 1'b0;
    io.mouse_left = 1'b0;
    chk("to_miss_lives", 32'(io.lives), 1);
    chk("to_miss_gs",    32'(io.game_state), 1);
    chk("to_miss_start", 32'(io.bug_start), 0);
`else
    tick_frames(600);
    chk("noto_lives", 32'(io.lives), 3);
    chk("noto_gs",    32'(io.game_state), 1);
    chk("noto_start", 32'(io.bug_start), 0);
`endif

    for (int i = 0; i < 256; i++) begin
      do_click(210, 210);
      tick_frames(30);
      cyc(1);
    end
    do_click(210, 210);
    chk("sat_score", 32'(io.score), 255);
    chk("sat_div",   32'(io.step_div), 8000);
    chk("sat_gs",    32'(io.game_state), 2);

    // Asynchronous reset while in HIT.
    #2 rst = 1'b1;
    #1;
    chk("arst_brst",  32'(io.bug_rst), 1);
    chk("arst_gs",    32'(io.game_state), 0);
    chk("arst_flash", 32'(io.hit_flash), 0);
    chk("arst_score", 32'(io.score), 0);
    chk("arst_lives", 32'(io.lives), 0);
    chk("arst_div",   32'(io.step_div), 40000);
    chk("arst_start", 32'(io.bug_start), 0);
    cyc(1);
    chk("arst_gs_next", 32'(io.game_state), 0);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_gs", 32'(io.game_state), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/bug_game_ctl.md
# bug_game_ctl

Game sequencer for the bug-chase screen. Owns the bug mover: holds it in reset, releases it with a start pulse, and programs its step divider (speed). Hit-tests left-button clicks against the bug's bounding box, keeps score and lives, and runs a per-round frame timer. Sits between the mouse front-end, the bug mover and the score/overlay renderer, all in the pclk domain.

## Interface
- BUG_W, 53, bug sprite width in pixels
- BUG_H, 54, bug sprite height in pixels
- LIVES, 3, lives loaded at game start (1..3)
- INIT_DIV, 40000, step divider loaded at game start
- DIV_DEC, 4000, divider decrement per hit
- MIN_DIV, 8000, divider floor
- HIT_FRAMES, 30, frames spent in HIT before re-arming
- ROUND_FRAMES, 600, frames allowed per round before timeout
- pclk  in  1  pixel clock, only clock
- rst  in  1  asynchronous reset, active-high
- mouse_left  in  1  left button level, synchronous to pclk
- mouse_xpos, mouse_ypos  in  12 each  cursor position
- bug_xpos, bug_ypos  in  12 each  bug top-left position from the mover
- frame_tick  in  1  one-cycle pulse per frame
- bug_rst  out  1  level; holds the mover in reset
- bug_start  out  1  one-cycle start pulse to the mover
- step_div  out  16  mover step divider
- score  out  8  hit count, saturating
- lives  out  2  remaining lives
- game_state  out  2  0 IDLE, 1 PLAY, 2 HIT, 3 OVER
- hit_flash  out  1  high during HIT

## Operation
- Click event = mouse_left high now and low on the previous cycle (registered previous sample).
- Hit test, done at 13-bit width so there is no wrap: bug_xpos ≤ mouse_xpos < bug_xpos+BUG_W and bug_ypos ≤ mouse_ypos < bug_ypos+BUG_H.
- IDLE: bug_rst=1. On a click → ARM, with score←0, lives←LIVES, step_div←INIT_DIV.
- ARM (reported as PLAY): one cycle with bug_rst=0 and bug_start=1, then → PLAY. The round frame counter clears.
- PLAY: bug_rst=0.
  - Click that hits: score←min(score+1, 255), step_div←max(step_div−DIV_DEC, MIN_DIV), → HIT.
  - Click that misses: lives−1. If the result is 0 → OVER; otherwise stay in PLAY and do not reset the timer.
  - Timeout (frame_tick while the counter equals ROUND_FRAMES−1): lives−1. If the result is 0 → OVER; otherwise → ARM.
  - Click and timeout in the same cycle: evaluate the click only. A hit wins; a miss costs exactly one life.
- HIT: bug_rst=1, hit_flash=1. Count HIT_FRAMES frame_ticks, then → ARM.
- OVER: bug_rst=1. Score and lives are held. A click → IDLE. That click does not also start a game.
- Clicks in ARM and HIT are ignored.
- Decrementing lives at 0 is unreachable; treat it as saturating.

## Timing
- All outputs are registered.
- Reset values: game_state=IDLE, bug_rst=1, bug_start=0, step_div=INIT_DIV, score=0, lives=0, hit_flash=0. All counters are 0.
- Latency: a click event seen in cycle N updates state, score and lives at the edge ending cycle N.
- bug_start is high for exactly one cycle, in the cycle after leaving IDLE or HIT, or after a non-fatal timeout.
- Frame counters advance only on frame_tick.
- Asserting rst mid-game returns to the reset values immediately. bug_rst goes high asynchronously.
- mouse_left held high across the IDLE→ARM transition does not generate further clicks.

## Configuration
- BUG_GAME_TIMEOUT_EN defined: round timer present; timeouts cost lives as described above.
- Not defined: the round counter is not built. Only missed clicks cost lives, and HIT→ARM is the only re-arm path. All other behaviour is identical.

## Structure
- Package bug_game_pkg holds:
  - the state enum with the encodings above;
  - the game_state output codes;
  - default constants for BUG_W, BUG_H, LIVES, INIT_DIV, DIV_DEC, MIN_DIV, HIT_FRAMES, ROUND_FRAMES.
- Sub-module mouse_click_edge: registered previous sample plus rising-edge pulse. Reused by future clickable blocks.
- Hit-box compare and FSM stay inline.

## Test plan
- Reset, then a click at (0,0) with bug at (100,100), 53×54 box → ARM, bug_start single pulse, PLAY, score 0, lives 3, step_div 40000.
- In PLAY, bug at (200,200), click at (252,253) → score 1, step_div 36000, HIT for 30 frames, then bug_start pulse. A click at (253,200) instead → miss, lives 2.
- Eight hits → step_div sequence floors at 8000. 256 hits → score stays 255.
- Three misses → OVER, lives 0, bug_rst 1. Next click → IDLE. Following click → new game with score 0.
- With BUG_GAME_TIMEOUT_EN: 600 frame_ticks in PLAY without a click → lives−1 and re-arm. A hit click in the same cycle as the 600th tick → score+1, lives unchanged.
- rst pulsed during HIT → all outputs at reset values next cycle, game_state IDLE.
